hazard_fwd_unit: RTL

//  Decode-stage hazard unit for the RV32 pipeline. Tracks the destination registers
//  of the last DEPTH issued instructions and outputs, per source operand, the

---
 rtl/rv32_pkg.sv | 53 +++++
 rtl/rd_history.sv | 52 +++++
 rtl/hazard_fwd_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants, history entry type and opcode classification
// used by the decode-stage hazard/forwarding unit.
package rv32_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam int SEL_RF       = 0;
    localparam int SEL_PC_IMM   = 1;
    localparam int SEL_FWD_BASE = 1;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } hist_entry_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic writes_rd;
        logic is_load;
        logic is_branch;
        logic def_a;
        logic def_b;
    } op_class_t;

    function automatic op_class_t decode_class(input logic [4:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_R:      begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.writes_rd = 1'b1; end
            OP_IMM:    begin c.use_rs1 = 1'b1; c.writes_rd = 1'b1; c.def_b = 1'b1; end
            OP_LOAD:   begin c.use_rs1 = 1'b1; c.writes_rd = 1'b1; c.is_load = 1'b1; c.def_b = 1'b1; end
            OP_JALR:   begin c.use_rs1 = 1'b1; c.writes_rd = 1'b1; c.def_b = 1'b1; end
            OP_STORE:  begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.def_b = 1'b1; end
            OP_BRANCH: begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.is_branch = 1'b1; end
            OP_LUI:    begin c.writes_rd = 1'b1; c.def_b = 1'b1; end
            OP_AUIPC:  begin c.writes_rd = 1'b1; c.def_a = 1'b1; c.def_b = 1'b1; end
            OP_JAL:    begin c.writes_rd = 1'b1; c.def_a = 1'b1; c.def_b = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rd_history.sv
// Shift register of destination-register records for the last DEPTH issued
// instructions; entry 0 is the instruction currently in EX.
module rd_history
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_bubble,
    input  logic                     i_kill0,
    input  hist_entry_t              i_entry,
    output hist_entry_t [DEPTH-1:0]  o_hist
);

    hist_entry_t [DEPTH-1:0] r_hist;
    hist_entry_t [DEPTH-1:0] w_next;

    // Next history: new entry at the head, older entries shift down; a squashed EX entry is cleared.
    always_comb begin
        w_next = r_hist;
        if (i_push) begin
            if (i_bubble) begin
                w_next[0] = '0;
            end else begin
                w_next[0] = i_entry;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (i == 1 && i_kill0) begin
                    w_next[i] = '0;
                end else begin
                    w_next[i] = r_hist[i-1];
                end
            end
        end else begin
            w_next = r_hist;
        end
    end

    // History register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else begin
            r_hist <= w_next;
        end
    end

    assign o_hist = r_hist;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard unit: per-operand forwarding selects from the recent
// destination history, one-cycle load-use stall, and flush handling.
module hazard_fwd_unit
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SELW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic            flush,
    output logic            stall,
    output logic [SELW-1:0] sel_a,
    output logic [SELW-1:0] sel_b,
    output logic [SELW-1:0] sel_cmp_a,
    output logic [SELW-1:0] sel_cmp_b
);

    op_class_t               w_cls;
    logic [4:0]              w_rs1;
    logic [4:0]              w_rs2;
    logic [4:0]              w_rd;
    hist_entry_t [DEPTH-1:0] w_hist;
    hist_entry_t             w_entry;
    logic [SELW-1:0]         w_fwd1;
    logic [SELW-1:0]         w_fwd2;
    logic                    w_ld_hit;
    logic                    w_push;
    logic                    w_bubble;
    logic                    w_unused_bits;

    assign w_cls         = decode_class(instr[6:2]);
    assign w_rs1         = instr[19:15];
    assign w_rs2         = instr[24:20];
    assign w_rd          = instr[11:7];
    assign w_unused_bits = ^{instr[31:25], instr[14:12], instr[1:0]};

    // Scan oldest to youngest so the youngest matching producer is the one kept.
    function automatic logic [SELW-1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                                 input hist_entry_t [DEPTH-1:0] h);
        logic [SELW-1:0] s;
        s = SELW'(SEL_RF);
        if (used && rs != 5'd0) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (h[k-1].v && h[k-1].rd == rs) begin
                    s = SELW'(SEL_FWD_BASE + k);
                end else begin
                    s = s;
                end
            end
        end else begin
            s = SELW'(SEL_RF);
        end
        return s;
    endfunction

    assign w_fwd1 = fwd_sel(w_rs1, instr_valid & w_cls.use_rs1, w_hist);
    assign w_fwd2 = fwd_sel(w_rs2, instr_valid & w_cls.use_rs2, w_hist);

    // Load-use: the EX instruction is a load whose result a used source needs.
    always_comb begin
        w_ld_hit = 1'b0;
        if (instr_valid && !flush && w_hist[0].v && w_hist[0].ld) begin
            w_ld_hit = (w_cls.use_rs1 && w_rs1 != 5'd0 && w_hist[0].rd == w_rs1) ||
                       (w_cls.use_rs2 && w_rs2 != 5'd0 && w_hist[0].rd == w_rs2);
        end else begin
            w_ld_hit = 1'b0;
        end
    end

    // Operand selects: defaults per class, forwarding overrides; branches forward only to the comparator.
    always_comb begin
        stall     = w_ld_hit;
        sel_a     = SELW'(SEL_RF);
        sel_b     = SELW'(SEL_RF);
        sel_cmp_a = SELW'(SEL_RF);
        sel_cmp_b = SELW'(SEL_RF);
        if (!instr_valid) begin
            sel_a = SELW'(SEL_RF);
        end else if (w_cls.is_branch) begin
            sel_a     = SELW'(SEL_PC_IMM);
            sel_b     = SELW'(SEL_PC_IMM);
            sel_cmp_a = w_fwd1;
            sel_cmp_b = w_fwd2;
        end else begin
            if (w_fwd1 != SELW'(SEL_RF)) begin
                sel_a = w_fwd1;
            end else begin
                sel_a = w_cls.def_a ? SELW'(SEL_PC_IMM) : SELW'(SEL_RF);
            end
            if (w_fwd2 != SELW'(SEL_RF)) begin
                sel_b = w_fwd2;
            end else begin
                sel_b = w_cls.def_b ? SELW'(SEL_PC_IMM) : SELW'(SEL_RF);
            end
        end
    end

    assign w_push   = instr_valid | flush;
    assign w_bubble = w_ld_hit | flush;
    assign w_entry  = '{v: w_cls.writes_rd & (w_rd != 5'd0), rd: w_rd, ld: w_cls.is_load};

    rd_history #(
        .DEPTH (DEPTH)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_bubble (w_bubble),
        .i_kill0  (flush),
        .i_entry  (w_entry),
        .o_hist   (w_hist)
    );

endmodule
